// File: rtl/memc_pkg.sv
// Shared definitions for the BRAM memory controller host side: state encoding,
// default bus widths and the controller's BIST patterns.
package memc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int WAIT_W         = 3;

    // Patterns the controller writes during its power-on self test.
    localparam logic [7:0] BIST_PAT_A = 8'h55;
    localparam logic [7:0] BIST_PAT_B = 8'hAA;

    typedef enum logic [6:0] {
        ST_BOOT   = 7'b0000001,
        ST_IDLE   = 7'b0000010,
        ST_SETUP  = 7'b0000100,
        ST_STROBE = 7'b0001000,
        ST_WAIT   = 7'b0010000,
        ST_RESP   = 7'b0100000,
        ST_ERROR  = 7'b1000000
    } host_state_t;

endpackage

// File: rtl/memc_host_timer.sv
// Loadable down-counter that saturates at zero; used for read-latency/write-gap
// waiting and for the busy timeout.
module memc_host_timer #(
    parameter int WIDTH = 3,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= WIDTH'(INIT);
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memc_host.sv
// Request-side initiator for the BRAM memory controller. Optional busy timeout
// is enabled with MEMC_HOST_TIMEOUT_EN.
module memc_host
    import memc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY     = 3,
    parameter int TIMEOUT_CYCLES = 32768
) (
    input  logic                  host_clk,
    input  logic                  host_reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  host_err,
    input  logic                  memc_busy,
    output logic                  memc_rd_enable,
    output logic                  memc_wr_enable,
    output logic [ADDR_WIDTH-1:0] memc_addr,
    output logic [DATA_WIDTH-1:0] memc_wr_data,
    input  logic [DATA_WIDTH-1:0] memc_rd_data
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("memc_host: RD_LATENCY must be 1..7");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memc_host: TIMEOUT_CYCLES must be positive");
    end

    host_state_t       state, state_nxt;
    logic              lat_we;
    logic              wait_zero;
    logic              tmo;
    logic [WAIT_W-1:0] wait_val;

    // WAIT lasts wait_val+1 cycles: RD_LATENCY for reads, one for writes.
    assign wait_val = lat_we ? '0 : WAIT_W'(RD_LATENCY - 1);

    memc_host_timer #(.WIDTH(WAIT_W), .INIT(0)) u_wait (
        .clk      (host_clk),
        .reset    (host_reset),
        .load     (state == ST_STROBE),
        .load_val (wait_val),
        .dec      (state == ST_WAIT),
        .zero     (wait_zero)
    );

`ifdef MEMC_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic busy_wait, tmo_zero;

    assign busy_wait = (state == ST_BOOT) || (state == ST_SETUP);

    // Reloads on any break in the busy run, so only consecutive busy cycles count.
    memc_host_timer #(.WIDTH(TMO_W), .INIT(TIMEOUT_CYCLES - 1)) u_tmo (
        .clk      (host_clk),
        .reset    (host_reset),
        .load     (!memc_busy || !busy_wait || state_nxt != state),
        .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
        .dec      (memc_busy && busy_wait),
        .zero     (tmo_zero)
    );

    assign tmo = memc_busy && busy_wait && tmo_zero;

    always_ff @(posedge host_clk) begin
        if (host_reset) host_err <= 1'b0;
        else            host_err <= (state_nxt == ST_ERROR);
    end
`else
    assign tmo      = 1'b0;
    assign host_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:   if (!memc_busy) state_nxt = ST_IDLE;
                       else if (tmo)   state_nxt = ST_ERROR;
            ST_IDLE:   if (req_valid)  state_nxt = ST_SETUP;
            ST_SETUP:  if (!memc_busy) state_nxt = ST_STROBE;
                       else if (tmo)   state_nxt = ST_ERROR;
            ST_STROBE: state_nxt = ST_WAIT;
            ST_WAIT:   if (wait_zero)  state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_BOOT;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge host_clk) begin
        if (host_reset) begin
            state          <= ST_BOOT;
            lat_we         <= 1'b0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            memc_rd_enable <= 1'b0;
            memc_wr_enable <= 1'b0;
            memc_addr      <= '0;
            memc_wr_data   <= '0;
        end else begin
            state          <= state_nxt;
            req_ready      <= (state_nxt == ST_IDLE);
            rsp_valid      <= (state_nxt == ST_RESP);
            memc_rd_enable <= (state_nxt == ST_STROBE) && !lat_we;
            memc_wr_enable <= (state_nxt == ST_STROBE) && lat_we;
            if (state == ST_IDLE && req_valid) begin
                lat_we       <= req_we;
                memc_addr    <= req_addr;
                memc_wr_data <= req_wdata;
            end
            if (state == ST_WAIT && wait_zero && !lat_we)
                rsp_rdata <= memc_rd_data;
        end
    end

endmodule

// File: tb/tb_memc_host.sv
// Randomised self-checking bench for memc_host with a BRAM controller model and
// a transaction-level reference (memory image plus latency rules).
module tb_memc_host;

    localparam int DW  = 8;
    localparam int AW  = 12;
    localparam int L   = 3;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          host_reset, req_valid, req_ready, req_we;
    logic          rsp_valid, host_err, memc_busy, memc_rd_enable, memc_wr_enable;
    logic [AW-1:0] req_addr, memc_addr;
    logic [DW-1:0] req_wdata, rsp_rdata, memc_wr_data, memc_rd_data;

    always #5 clk = ~clk;

    memc_host #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L), .TIMEOUT_CYCLES(TMO)) dut (
        .host_clk(clk), .host_reset(host_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .host_err(host_err),
        .memc_busy(memc_busy), .memc_rd_enable(memc_rd_enable), .memc_wr_enable(memc_wr_enable),
        .memc_addr(memc_addr), .memc_wr_data(memc_wr_data), .memc_rd_data(memc_rd_data)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 12'h123) return 8'h5A;
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h96;
    endfunction

    // Controller model: write on strobe, read data appears L cycles after the strobe cycle.
    logic [DW-1:0] ctl_mem [0:4095];
    logic          ctl_wr  [0:4095];
    logic [DW-1:0] pipe_d  [0:7];
    logic          pipe_v  [0:7];

    always @(posedge clk) begin
        if (memc_wr_enable) begin
            ctl_mem[memc_addr] <= memc_wr_data;
            ctl_wr[memc_addr]  <= 1'b1;
        end
        pipe_d[0] <= (ctl_wr[memc_addr] === 1'b1) ? ctl_mem[memc_addr] : init_val(memc_addr);
        pipe_v[0] <= memc_rd_enable;
        for (int i = 1; i < 8; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end

    assign memc_rd_data = (pipe_v[L-1] === 1'b1) ? pipe_d[L-1] : 8'hEE;

    // Bus monitor: strobe spacing, exclusivity, address setup.
    int            cyc = 0;
    int            last_stb = -1000;
    int            stb_cyc = 0;
    int            rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memc_rd_enable || memc_wr_enable) begin
            chk("strobe_gap", 32'((cyc - last_stb - 1) >= 3), 32'd1);
            chk("strobe_excl", 32'(memc_rd_enable && memc_wr_enable), 32'd0);
            chk("addr_pre_strobe", 32'(memc_addr), 32'(prev_addr));
            last_stb = cyc;
            stb_cyc  = cyc;
            if (memc_rd_enable) rd_cnt++;
            if (memc_wr_enable) wr_cnt++;
        end
        if (rsp_valid) rsp_cnt++;
        prev_addr = memc_addr;
    end

    logic [DW-1:0] ref_mem [0:4095];

    task automatic wait_ready(output int w);
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic boot(input int hold);
        int bad = 0;
        int s0;
        host_reset = 1'b1;
        memc_busy  = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_err", 32'(host_err), 0);
        chk("rst_rd_en", 32'(memc_rd_enable), 0);
        chk("rst_wr_en", 32'(memc_wr_enable), 0);
        chk("rst_addr", 32'(memc_addr), 0);
        chk("rst_wdata", 32'(memc_wr_data), 0);
        host_reset = 1'b0;
        s0 = rd_cnt + wr_cnt;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (req_ready) bad++;
        end
        chk("boot_ready_low", 32'(bad), 0);
        chk("boot_no_strobe", 32'(rd_cnt + wr_cnt - s0), 0);
        memc_busy = 1'b0;
        @(negedge clk);
        chk("boot_ready", 32'(req_ready), 1);
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int stall, input logic wbusy, input logic keep, input logic gapchk);
        int w, c0, rd0, wr0, lat;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        wait_ready(w);
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (gapchk) chk("b2b_gap", 32'(w), 1);
        c0  = cyc;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = keep;
        if (stall > 0) begin
            memc_busy = 1'b1;
            repeat (stall) @(negedge clk);
            memc_busy = 1'b0;
        end else if (wbusy) begin
            @(negedge clk);
            @(negedge clk);
            memc_busy = 1'b1;
            @(negedge clk);
            memc_busy = 1'b0;
        end
        while (!rsp_valid && (cyc - c0) < 100) @(negedge clk);
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        lat = cyc - c0;
        chk(we ? "wr_latency" : "rd_latency", 32'(lat), 32'((we ? 4 : 3 + L) + stall));
        chk("strobe_cycle", 32'(stb_cyc - c0), 32'(2 + stall));
        chk("rd_strobes", 32'(rd_cnt - rd0), we ? 0 : 1);
        chk("wr_strobes", 32'(wr_cnt - wr0), we ? 1 : 0);
        chk("addr_hold", 32'(memc_addr), 32'(a));
        if (we) begin
            chk("wr_data", 32'(memc_wr_data), 32'(d));
            ref_mem[a] = d;
        end else begin
            chk("rd_data", 32'(rsp_rdata), 32'(ref_mem[a]));
        end
    endtask

    task automatic rst_in_wait(input logic [AW-1:0] a);
        int w, r0, s0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        wait_ready(w);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r0 = rsp_cnt;
        s0 = rd_cnt + wr_cnt;
        boot(4);
        repeat (6) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_cnt - r0), 0);
        chk("rst_no_strobe", 32'(rd_cnt + wr_cnt - s0), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(AW'(i));
        host_reset = 1'b1;
        memc_busy  = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(negedge clk);

`ifdef MEMC_HOST_TIMEOUT_EN
        host_reset = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        chk("tmo_early", 32'(host_err), 0);
        @(negedge clk);
        chk("tmo_err", 32'(host_err), 1);
        memc_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("tmo_sticky", 32'(host_err), 1);
        chk("tmo_ready", 32'(req_ready), 0);
        req_valid = 1'b1;
        boot(10);
`else
        req_valid = 1'b1;
        boot(24600);
        chk("no_err", 32'(host_err), 0);
`endif

        do_req(1'b0, 12'h000, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        do_req(1'b1, 12'h3FF, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
        do_req(1'b0, 12'h123, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        do_req(1'b0, 12'h3FF, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        do_req(1'b0, 12'hFFF, 8'h00, 0, 1'b0, 1'b1, 1'b0);
        do_req(1'b1, 12'h000, 8'h3C, 0, 1'b0, 1'b1, 1'b1);
        do_req(1'b0, 12'h000, 8'h00, 0, 1'b0, 1'b0, 1'b1);
        chk("b2b_final_rdata", 32'(rsp_rdata), 32'h3C);

        do_req(1'b1, 12'h555, 8'h77, 10, 1'b0, 1'b0, 1'b0);
        do_req(1'b0, 12'h555, 8'h00, 10, 1'b0, 1'b0, 1'b0);

        rst_in_wait(12'h123);
        do_req(1'b0, 12'h123, 8'h00, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic          we;
            logic [AW-1:0] a;
            int            stall, gap;
            logic          wb;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = 12'h000;
                1:       a = 12'hFFF;
                default: a = {8'h80, 4'($urandom_range(0, 15))};
            endcase
            stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
            wb    = (stall == 0) && ($urandom_range(0, 3) == 0);
            gap   = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            do_req(we, a, 8'($urandom), stall, wb, 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
